// File: rtl/seq_alu.sv
// Multicycle ALU with Start/Busy/Done handshake: single-cycle logic ops plus iterative
// unsigned MUL and (when SEQ_ALU_DIV_EN is defined) restoring unsigned DIVU.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] OutHi,
    output logic             Zero,
    output logic             DivZero,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] outhi_q, outhi_d;
    logic             zero_q, zero_d;
    logic             divz_q, divz_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] res_lo, res_hi;
    logic             res_dz, go_run;
`ifdef SEQ_ALU_DIV_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   div_r, div_diff;
`endif

    // One iteration: {hi,lo} shift-add for MUL; hi = partial remainder, lo = dividend/quotient for DIVU.
    always_comb begin
        mul_sum = {1'b0, hi_q} + ({1'b0, b_q} & {(WIDTH+1){lo_q[0]}});
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_r    = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_r - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_r[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        out_d   = out_q;
        outhi_d = outhi_q;
        divz_d  = divz_q;
`ifdef SEQ_ALU_DIV_EN
        is_div_d = is_div_q;
`endif
        res_lo  = '0;
        res_hi  = '0;
        res_dz  = 1'b0;
        go_run  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    case (ALUOp)
                        4'b0000: res_lo = In1 + In2;
                        4'b0001: res_lo = In1 - In2;
                        4'b0010: res_lo = In1 & In2;
                        4'b0011: res_lo = In1 | In2;
                        4'b0100: res_lo = ~In1;
                        4'b0101: res_lo = In1;
                        4'b0110: res_lo = In2;
                        4'b0111: res_lo[0] = $signed(In1) < $signed(In2);
                        4'b1000: go_run = 1'b1;
`ifdef SEQ_ALU_DIV_EN
                        4'b1001: begin
                            if (In2 == '0) begin
                                res_lo = '1;
                                res_hi = In1;
                                res_dz = 1'b1;
                            end else begin
                                go_run = 1'b1;
                            end
                        end
`endif
                        default: res_lo = '0;
                    endcase
                    if (go_run) begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH-1);
                        b_d     = In2;
                        lo_d    = In1;
                        hi_d    = '0;
`ifdef SEQ_ALU_DIV_EN
                        is_div_d = ALUOp[0];
`endif
                    end else begin
                        state_d = DONE;
                        out_d   = res_lo;
                        outhi_d = res_hi;
                        divz_d  = res_dz;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    out_d   = step_lo;
                    outhi_d = step_hi;
                    divz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            outhi_q <= '0;
            zero_q  <= 1'b1;
            divz_q  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            outhi_q <= outhi_d;
            zero_q  <= zero_d;
            divz_q  <= divz_d;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign Out     = out_q;
    assign OutHi   = outhi_q;
    assign Zero    = zero_q;
    assign DivZero = divz_q;
    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == DONE);
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multicycle ALU for the MIPS multicycle datapath. It extends the single-cycle 16-bit ALU operation set with a signed set-less-than, an iterative unsigned multiplier and an iterative unsigned divider. The block sits between the A/B operand registers and ALUOut. The controller runs it with a Start/Busy/Done handshake, so long operations stall the FSM instead of lengthening the clock period.

## Interface
- WIDTH, 16: operand and result width in bits; must be at least 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- Start  input  1  request; sampled only in IDLE or DONE.
- ALUOp  input  4  operation code; sampled with Start.
- In1  input  WIDTH  operand A; sampled with Start.
- In2  input  WIDTH  operand B; sampled with Start.
- Out  output  WIDTH  registered result: low product or quotient.
- OutHi  output  WIDTH  registered high product or remainder; 0 for all other ops.
- Zero  output  1  registered; equals (Out == 0).
- DivZero  output  1  registered; set by DIVU when In2 == 0.
- Busy  output  1  high while an iterative op runs.
- Done  output  1  one-cycle pulse; results are valid from this cycle.

## Operation
- ALUOp codes:
  - 0000 ADD In1+In2, wrap modulo 2^WIDTH.
  - 0001 SUB In1-In2, wrap modulo 2^WIDTH.
  - 0010 AND.
  - 0011 OR.
  - 0100 NOT In1.
  - 0101 PASS In1.
  - 0110 PASS In2.
  - 0111 SLT: 1 if signed In1 < signed In2, else 0.
  - 1000 MUL: unsigned, 2*WIDTH-bit product {OutHi, Out}.
  - 1001 DIVU: Out = quotient, OutHi = remainder.
  - Others: Out = 0, single-cycle.
- States:
  - IDLE: waiting for Start.
  - RUN: iterative op in progress; Busy = 1.
  - DONE: Done = 1.
- Transitions:
  - IDLE or DONE with Start = 1 and a single-cycle op: next state DONE; results are computed from the sampled operands and registered.
  - IDLE or DONE with Start = 1 and MUL/DIVU: next state RUN. Operands are latched and the iteration counter is loaded with WIDTH-1.
  - IDLE or DONE with Start = 0: next state IDLE.
  - RUN: one shift-add (MUL) or restoring subtract (DIVU) step per cycle. The counter decrements, and when it reaches 0 the final step is written and the next state is DONE.
- Start is ignored in RUN. There is no abort.
- Operand changes after the Start cycle have no effect.
- DIVU with In2 == 0: no iteration, next state DONE. Out = all ones, OutHi = In1, DivZero = 1.
- DivZero is cleared on every other completion.
- Out, OutHi, Zero and DivZero update only in the cycle entering DONE and hold until the next completion.

## Timing
- Reset: state IDLE, Out = 0, OutHi = 0, Zero = 1, DivZero = 0, Busy = 0, Done = 0, counter = 0.
- rst_n low in any state, including mid-RUN, aborts the operation. The partial result is discarded and never appears on Out.
- Single-cycle ops: Start in cycle T, Done and valid results in T+1.
- MUL/DIVU: Start in T, Busy high T+1..T+WIDTH, Done in T+WIDTH+1 (WIDTH+1 latency).
- DIVU by zero: Done in T+1.
- Back-to-back: a Start asserted during the Done cycle is accepted. A single-cycle op then produces Done on consecutive cycles.
- Busy and Done are never high together.

## Configuration
- SEQ_ALU_DIV_EN defined: the DIVU datapath (remainder register, subtractor, DivZero logic) is built as described.
- Not defined:
  - ALUOp 1001 is handled as an undefined code: Out = 0, OutHi = 0, DivZero = 0, single-cycle.
  - DivZero is tied to 0.
  - MUL is unaffected.

## Test plan
- Reset: hold rst_n low 2 cycles -> Out = 0, OutHi = 0, Zero = 1, Busy = 0, Done = 0. Then Start ADD 0x7FFF+0x0001 -> next cycle Out = 0x8000, Zero = 0, Done = 1.
- SUB 0x0005-0x0005 -> Out = 0x0000, Zero = 1, Done at T+1. Then SLT 0xFFFF vs 0x0001 -> Out = 0x0001.
- MUL 0xFFFF*0xFFFF -> Busy for 16 cycles, Done at T+17, OutHi = 0xFFFE, Out = 0x0001. A Start pulse at T+5 is ignored.
- DIVU 100/7 -> Done at T+17, Out = 14, OutHi = 2, DivZero = 0. DIVU 0x1234/0 -> Done at T+1, Out = 0xFFFF, OutHi = 0x1234, DivZero = 1. Without SEQ_ALU_DIV_EN: Out = 0, DivZero = 0.
- Mid-RUN reset: MUL started, rst_n low at T+8 -> IDLE, Out = 0, no Done pulse. A new ADD 2+3 then completes with Out = 5.
- Back-to-back: ADD 1+1 with Start held for 3 cycles -> Done high 3 consecutive cycles, Out = 2 each cycle.
